// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply-divide controller signal bundle.
// The controller takes the slave modport; the pipeline/MDU side takes the master modport.
interface mdu_ctrl_if;
    logic [3:0]  d_md_op;
    logic [3:0]  e_md_op;
    logic        e_valid;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
    logic        mdu_start;
    logic [5:0]  mdu_func;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic        proto_err;
    logic [31:0] stall_cnt;
    logic        dbg_state;   // 1 while the latency FSM is BUSY

    modport slave (
        input  d_md_op, e_md_op, e_valid, mdu_busy, mdu_hi, mdu_lo,
        output mdu_start, mdu_func, md_stall, md_rdata, proto_err, stall_cnt, dbg_state
    );

    modport master (
        output d_md_op, e_md_op, e_valid, mdu_busy, mdu_hi, mdu_lo,
        input  mdu_start, mdu_func, md_stall, md_rdata, proto_err, stall_cnt, dbg_state
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU issue/stall controller: start/funct decode, latency FSM, D-stage stall, HI/LO read mux, error flag.
// Optional stall-cycle counter is enabled by defining MDU_STALL_CNT_EN.
module mdu_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic     clk,
    input  logic     reset,
    mdu_ctrl_if.slave bus
);
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_proto_err, w_proto_nxt;
    logic             w_is_calc, w_is_mtx, w_start, w_stall;
    logic [5:0]       w_func;
    logic [31:0]      w_rdata, w_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_proto_err <= w_proto_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_func      = 6'd0;
        w_rdata     = 32'd0;
        w_is_calc   = bus.e_valid && (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd4);
        w_is_mtx    = bus.e_valid && ((bus.e_md_op == 4'd5) || (bus.e_md_op == 4'd6));

        case (r_state)
            S_IDLE: begin
                if (w_is_calc) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = (bus.e_md_op <= 4'd2) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                end
            end
            S_BUSY: begin
                // Leaves on the same edge the MDU commits HI/LO and drops BUSY.
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_start = !reset && (r_state == S_IDLE) && w_is_calc;

        if (!reset && bus.e_valid) begin
            case (bus.e_md_op)
                4'd1:    w_func = FN_MULT;
                4'd2:    w_func = FN_MULTU;
                4'd3:    w_func = FN_DIV;
                4'd4:    w_func = FN_DIVU;
                4'd5:    w_func = FN_MTHI;
                4'd6:    w_func = FN_MTLO;
                4'd7:    w_rdata = bus.mdu_hi;
                4'd8:    w_rdata = bus.mdu_lo;
                default: w_func = 6'd0;
            endcase
        end

        // The start cycle must stall too: MDU BUSY only rises on the following edge.
        w_stall = !reset && (bus.d_md_op != 4'd0) &&
                  (w_start || (r_state == S_BUSY) || bus.mdu_busy);

        w_proto_nxt = r_proto_err
                    || ((r_state == S_BUSY) && (w_is_calc || w_is_mtx))
                    || (bus.mdu_busy != (r_state == S_BUSY))
                    || (bus.e_valid && (bus.e_md_op > 4'd8));
    end

`ifdef MDU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign w_stall_cnt = r_stall_cnt;
`else
    assign w_stall_cnt = 32'd0;
`endif

    assign bus.mdu_start = w_start;
    assign bus.mdu_func  = w_func;
    assign bus.md_stall  = w_stall;
    assign bus.md_rdata  = w_rdata;
    assign bus.proto_err = !reset && r_proto_err;
    assign bus.stall_cnt = reset ? 32'd0 : w_stall_cnt;
    assign bus.dbg_state = !reset && (r_state == S_BUSY);
endmodule
